// File: rtl/ft_bridge_pkg.sv
// Shared types and constants for the FT telemetry bridge.
package ft_bridge_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        LOOP   = 2'd3
    } bridge_state_t;

    // Leading byte of every frame header
    localparam logic [7:0] HEADER_MAGIC = 8'hA5;

    // Number of bus words needed to carry one packet (rounded up)
    function automatic int words_per_pkt(input int data_w, input int bus_w);
        return (data_w + bus_w - 1) / bus_w;
    endfunction

endpackage

// File: rtl/telem_chan_fifo.sv
// Per-channel packet FIFO with a saturating count of packets lost to overflow.
module telem_chan_fifo
    import ft_bridge_pkg::*;
#(
    parameter int DATA_W     = 88,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              not_empty,
    input  logic              clear_counts,
    output logic [15:0]       drop_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Fullness is judged before any same-cycle pop, so a full FIFO always drops
    assign full      = (count == CW'(FIFO_DEPTH));
    assign not_empty = (count != '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && not_empty;
    assign head_data = mem[rd_ptr];

    // Packet storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drop counter; a clear overrides a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clear_counts) drop_count <= '0;
        else if (push && full)   drop_count <= sat_inc16(drop_count);
    end

endmodule

// File: rtl/ft_telem_bridge.sv
// Multiplexes per-channel telemetry packets into headed frames on an FT
// user bus, with a host loopback mode that mirrors the receive path.
module ft_telem_bridge
    import ft_bridge_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 88,
    parameter int BUS_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [BUS_W-1:0]         ui_din,
    output logic [BUS_W/8-1:0]       ui_din_be,
    output logic                     ui_din_valid,
    input  logic                     ui_din_full,
    input  logic [BUS_W-1:0]         ui_dout,
    input  logic [BUS_W/8-1:0]       ui_dout_be,
    input  logic                     ui_dout_empty,
    output logic                     ui_dout_get,
    input  logic                     clear_counts,
    output logic [NUM_CH*16-1:0]     drop_count
);

    localparam int WORDS = words_per_pkt(DATA_W, BUS_W);
    localparam int PW    = WORDS * BUS_W;
    localparam int PAD   = PW - DATA_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    bridge_state_t     state;
    bridge_state_t     state_nx;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   last_ch;
    logic [CH_W-1:0]   rr_idx;
    logic [CH_W-1:0]   sel_ch;
    logic              sel_found;
    logic              take;
    logic              xfer;
    logic [WI_W-1:0]   word_idx;
    logic [3:0]        seq [NUM_CH];
    logic [DATA_W-1:0] pkt_p0;
    logic [DATA_W-1:0] fifo_head [NUM_CH];
    logic [NUM_CH-1:0] fifo_nempty;
    logic [NUM_CH-1:0] fifo_pop;
    logic [PW-1:0]     pkt_padded;
    logic [PW-1:0]     pkt_shifted;
    logic [BUS_W-1:0]  data_word;
    logic [BUS_W-1:0]  hdr_word;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        telem_chan_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push         (in_valid[k]),
            .push_data    (in_data[k*DATA_W +: DATA_W]),
            .pop          (fifo_pop[k]),
            .head_data    (fifo_head[k]),
            .not_empty    (fifo_nempty[k]),
            .clear_counts (clear_counts),
            .drop_count   (drop_count[k*16 +: 16])
        );
    end

    // Round-robin pick: first non-empty channel after the one served last
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        rr_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_idx = CH_W'((int'(last_ch) + 1 + i) % NUM_CH);
            if (!sel_found && fifo_nempty[rr_idx]) begin
                sel_found = 1'b1;
                sel_ch    = rr_idx;
            end
        end
    end

    assign take = (state == IDLE) && !mode && sel_found;
    assign xfer = ui_din_valid && !ui_din_full;

    // Packet is left-justified so word 0 carries the MSBs and padding lands at the LSB end
    assign pkt_padded  = PW'(pkt_p0) << PAD;
    assign pkt_shifted = pkt_padded << (word_idx * BUS_W);
    assign data_word   = pkt_shifted[PW-1 -: BUS_W];
    assign hdr_word    = BUS_W'({HEADER_MAGIC, 4'(cur_ch), seq[cur_ch]});

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; mode is only looked at between frames
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mode)           state_nx = LOOP;
                else if (sel_found) state_nx = HEADER;
            end
            HEADER: if (xfer) state_nx = DATA;
            DATA:   if (xfer && word_idx == WI_W'(WORDS - 1)) state_nx = IDLE;
            LOOP:   if (!mode) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic; everything is held quiet while reset is asserted
    always_comb begin
        ui_din       = '0;
        ui_din_be    = '0;
        ui_din_valid = 1'b0;
        ui_dout_get  = 1'b0;
        fifo_pop     = '0;
        if (!rst) begin
            ui_dout_get = !ui_dout_empty;
            case (state)
                IDLE: if (take) fifo_pop[sel_ch] = 1'b1;
                HEADER: begin
                    ui_din       = hdr_word;
                    ui_din_be    = '1;
                    ui_din_valid = 1'b1;
                end
                DATA: begin
                    ui_din       = data_word;
                    ui_din_be    = '1;
                    ui_din_valid = 1'b1;
                end
                LOOP: begin
                    ui_din       = ui_dout;
                    ui_din_be    = ui_dout_be;
                    ui_din_valid = !ui_dout_empty;
                    ui_dout_get  = !ui_din_full;
                end
                default: ;
            endcase
        end
    end

    // Frame bookkeeping: served channel, word index and per-channel sequence numbers
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch   <= '0;
            last_ch  <= CH_W'(NUM_CH - 1);
            word_idx <= '0;
            for (int k = 0; k < NUM_CH; k++) seq[k] <= '0;
        end else begin
            if (take) begin
                cur_ch   <= sel_ch;
                last_ch  <= sel_ch;
                word_idx <= '0;
            end
            if (state == HEADER && xfer) seq[cur_ch] <= seq[cur_ch] + 4'd1;
            if (state == DATA && xfer)   word_idx <= word_idx + 1'b1;
        end
    end

    // Packet register captures the FIFO head as it is popped
    always_ff @(posedge clk) begin
        if (take) pkt_p0 <= fifo_head[sel_ch];
    end

endmodule

// File: tb/tb_ft_telem_bridge.sv
// Self-checking bench for ft_telem_bridge with a queue-based frame model.
module tb_ft_telem_bridge;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 88;
    localparam int BUS_W  = 16;

    logic                     clk;
    logic                     rst;
    logic                     mode;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [BUS_W-1:0]         ui_din;
    logic [BUS_W/8-1:0]       ui_din_be;
    logic                     ui_din_valid;
    logic                     ui_din_full;
    logic [BUS_W-1:0]         ui_dout;
    logic [BUS_W/8-1:0]       ui_dout_be;
    logic                     ui_dout_empty;
    logic                     ui_dout_get;
    logic                     clear_counts;
    logic [NUM_CH*16-1:0]     drop_count;

    ft_telem_bridge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BUS_W(BUS_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
        .ui_din(ui_din), .ui_din_be(ui_din_be), .ui_din_valid(ui_din_valid),
        .ui_din_full(ui_din_full), .ui_dout(ui_dout), .ui_dout_be(ui_dout_be),
        .ui_dout_empty(ui_dout_empty), .ui_dout_get(ui_dout_get),
        .clear_counts(clear_counts), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Transfer capture and hold-stability monitor
    logic [15:0] cap_w [$];
    logic [1:0]  cap_be [$];
    int          cap_cyc [$];
    int          stab_err = 0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_w;
    logic [1:0]  prev_be;

    always @(negedge clk) begin
        #2;
        if (!rst && prev_hold && ui_din_valid && (ui_din !== prev_w || ui_din_be !== prev_be))
            stab_err++;
        if (!rst && ui_din_valid && !ui_din_full) begin
            cap_w.push_back(ui_din);
            cap_be.push_back(ui_din_be);
            cap_cyc.push_back(cyc);
        end
        prev_hold = !rst && ui_din_valid && ui_din_full;
        prev_w    = ui_din;
        prev_be   = ui_din_be;
    end

    // Reference model: per-channel bounded queues, RR pointer, seq and drop counts
    logic [DATA_W-1:0] mq [NUM_CH][$];
    int                m_seq [NUM_CH];
    int                m_drop [NUM_CH];
    int                m_last;
    logic [15:0]       exp_w [$];

    function automatic void m_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            mq[k].delete();
            m_seq[k]  = 0;
            m_drop[k] = 0;
        end
        m_last = NUM_CH - 1;
    endfunction

    function automatic void m_push(input int ch, input logic [DATA_W-1:0] p);
        if (mq[ch].size() < 4) mq[ch].push_back(p);
        else if (m_drop[ch] < 65535) m_drop[ch]++;
    endfunction

    function automatic int m_pick();
        for (int i = 1; i <= NUM_CH; i++)
            if (mq[(m_last + i) % NUM_CH].size() > 0) return (m_last + i) % NUM_CH;
        return -1;
    endfunction

    function automatic void m_emit(input int ch);
        logic [DATA_W-1:0] p;
        logic [95:0]       padded;
        p      = mq[ch].pop_front();
        padded = {p, 8'h00};
        exp_w.push_back({8'hA5, 4'(ch), 4'(m_seq[ch])});
        for (int i = 0; i < 6; i++) exp_w.push_back(padded[95-16*i -: 16]);
        m_seq[ch] = (m_seq[ch] + 1) % 16;
        m_last    = ch;
    endfunction

    function automatic void m_drain();
        while (m_pick() >= 0) m_emit(m_pick());
    endfunction

    function automatic logic [DATA_W-1:0] rnd_pkt();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    function automatic void cap_clear();
        cap_w.delete();
        cap_be.delete();
        cap_cyc.delete();
        exp_w.delete();
    endfunction

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            #3;
            if (cap_w.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic idle_inputs();
        in_valid     = '0;
        clear_counts = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; in_valid = '0; in_data = '0; clear_counts = 1'b0;
        ui_din_full = 1'b0; ui_dout = 16'h1234; ui_dout_be = 2'b11; ui_dout_empty = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (ui_din_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ui_din_valid); else n_pass++;
        n_checks++; if (ui_din !== 16'h0) $display("FAIL reset_din got %h want 0000", ui_din); else n_pass++;
        n_checks++; if (ui_din_be !== 2'b00) $display("FAIL reset_be got %b want 00", ui_din_be); else n_pass++;
        n_checks++; if (ui_dout_get !== 1'b0) $display("FAIL reset_get got %b want 0", ui_dout_get); else n_pass++;
        n_checks++; if (drop_count !== 32'h0) $display("FAIL reset_drop got %h want 0", drop_count); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (ui_dout_get !== 1'b1) $display("FAIL idle_discard got %b want 1", ui_dout_get); else n_pass++;
        ui_dout_empty = 1'b1;
        #1;
        n_checks++; if (ui_dout_get !== 1'b0) $display("FAIL idle_nodiscard got %b want 0", ui_dout_get); else n_pass++;
        m_reset();
    endtask

    task automatic test_frame();
        logic [15:0] golden [7];
        bit ok;
        golden = '{16'hA500, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0123, 16'h4500};
        cap_clear();
        @(negedge clk);
        in_data[0 +: DATA_W] = 88'h0123456789ABCDEF012345;
        in_valid = 2'b01;
        m_push(0, 88'h0123456789ABCDEF012345);
        m_emit(0);
        @(negedge clk);
        in_valid = '0;
        #1;
        n_checks++; if (ui_din_valid !== 1'b0) $display("FAIL latency_n1 got %b want 0", ui_din_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (ui_din_valid !== 1'b1 || ui_din !== 16'hA500) $display("FAIL latency_n2 got %b/%h want 1/a500", ui_din_valid, ui_din); else n_pass++;
        wait_words(7, 50, ok);
        n_checks++; if (!ok) $display("FAIL frame_timeout got %0d words want 7", cap_w.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (cap_w[i] !== golden[i] || cap_be[i] !== 2'b11) $display("FAIL frame_word%0d got %h/%b want %h/11", i, cap_w[i], cap_be[i], golden[i]); else n_pass++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] a, b, c;
        bit ok;
        test_reset();
        cap_clear();
        a = rnd_pkt(); b = rnd_pkt(); c = rnd_pkt();
        @(negedge clk);
        in_data = {b, a};
        in_valid = 2'b11;
        m_push(0, a); m_push(1, b);
        m_emit(m_pick());
        @(negedge clk);
        in_data[0 +: DATA_W] = c;
        in_valid = 2'b01;
        m_push(0, c);
        m_drain();
        @(negedge clk);
        in_valid = '0;
        wait_words(21, 100, ok);
        n_checks++; if (!ok) $display("FAIL rr_timeout got %0d words want 21", cap_w.size()); else n_pass++;
        n_checks++; if (exp_w[0] !== 16'hA500 || exp_w[7] !== 16'hA510 || exp_w[14] !== 16'hA501) $display("FAIL rr_model_order got %h %h %h want a500 a510 a501", exp_w[0], exp_w[7], exp_w[14]); else n_pass++;
        for (int i = 0; i < 21; i++) begin
            n_checks++; if (cap_w[i] !== exp_w[i]) $display("FAIL rr_word%0d got %h want %h", i, cap_w[i], exp_w[i]); else n_pass++;
        end
        n_checks++; if (cap_cyc[6] - cap_cyc[0] != 6) $display("FAIL frame_contiguous got %0d want 6", cap_cyc[6] - cap_cyc[0]); else n_pass++;
        n_checks++; if (cap_cyc[7] - cap_cyc[6] != 2) $display("FAIL b2b_gap1 got %0d want 2", cap_cyc[7] - cap_cyc[6]); else n_pass++;
        n_checks++; if (cap_cyc[14] - cap_cyc[13] != 2) $display("FAIL b2b_gap2 got %0d want 2", cap_cyc[14] - cap_cyc[13]); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] p;
        bit ok;
        cap_clear();
        @(negedge clk);
        ui_din_full = 1'b1;
        p = rnd_pkt();
        in_data[0 +: DATA_W] = p;
        in_valid = 2'b01;
        m_push(0, p);
        m_emit(m_pick());
        @(negedge clk);
        in_valid = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            p = rnd_pkt();
            in_data[DATA_W +: DATA_W] = p;
            in_valid = 2'b10;
            m_push(1, p);
            @(negedge clk);
        end
        in_valid = '0;
        #1;
        n_checks++; if (drop_count[16 +: 16] !== 16'(m_drop[1]) || m_drop[1] != 2) $display("FAIL drop_ch1 got %0d want 2", drop_count[16 +: 16]); else n_pass++;
        n_checks++; if (drop_count[0 +: 16] !== 16'h0) $display("FAIL drop_ch0 got %0d want 0", drop_count[0 +: 16]); else n_pass++;
        @(negedge clk);
        in_data[DATA_W +: DATA_W] = rnd_pkt();
        in_valid = 2'b10;
        clear_counts = 1'b1;
        m_drop[1] = 0;
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (drop_count[16 +: 16] !== 16'h0) $display("FAIL clear_wins got %0d want 0", drop_count[16 +: 16]); else n_pass++;
        n_checks++; if (stab_err != 0) $display("FAIL hold_header got %0d unstable cycles want 0", stab_err); else n_pass++;
        ui_din_full = 1'b0;
        m_drain();
        wait_words(exp_w.size(), 300, ok);
        n_checks++; if (!ok) $display("FAIL ovf_timeout got %0d words want %0d", cap_w.size(), exp_w.size()); else n_pass++;
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++; if (cap_w[i] !== exp_w[i]) $display("FAIL ovf_word%0d got %h want %h", i, cap_w[i], exp_w[i]); else n_pass++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure_mode();
        logic [DATA_W-1:0] p;
        logic [15:0]       held;
        bit ok;
        cap_clear();
        stab_err = 0;
        @(negedge clk);
        p = rnd_pkt();
        in_data[DATA_W +: DATA_W] = p;
        in_valid = 2'b10;
        m_push(1, p);
        m_emit(m_pick());
        @(negedge clk);
        in_valid = '0;
        wait_words(2, 20, ok);
        n_checks++; if (!ok) $display("FAIL bp_start_timeout got %0d words want 2", cap_w.size()); else n_pass++;
        @(negedge clk);
        ui_din_full = 1'b1;
        mode = 1'b1;
        #1;
        held = ui_din;
        repeat (5) begin
            @(negedge clk);
            #1;
            n_checks++; if (ui_din_valid !== 1'b1 || ui_din !== held) $display("FAIL bp_hold got %b/%h want 1/%h", ui_din_valid, ui_din, held); else n_pass++;
        end
        @(negedge clk);
        ui_din_full = 1'b0;
        wait_words(7, 50, ok);
        n_checks++; if (!ok) $display("FAIL bp_timeout got %0d words want 7", cap_w.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (cap_w[i] !== exp_w[i]) $display("FAIL bp_word%0d got %h want %h", i, cap_w[i], exp_w[i]); else n_pass++;
        end
        n_checks++; if (stab_err != 0) $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err); else n_pass++;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (ui_dout_get !== 1'b1 || ui_din_valid !== 1'b0) $display("FAIL loop_empty got get=%b valid=%b want 1/0", ui_dout_get, ui_din_valid); else n_pass++;
        @(negedge clk);
        ui_dout = 16'(($urandom() & 32'hFFFF));
        ui_dout_be = 2'b01;
        ui_dout_empty = 1'b0;
        ui_din_full = 1'b1;
        #1;
        n_checks++; if (ui_din_valid !== 1'b1 || ui_din !== ui_dout || ui_din_be !== 2'b01 || ui_dout_get !== 1'b0) $display("FAIL loop_entered got %b/%h/%b/%b want 1/%h/01/0", ui_din_valid, ui_din, ui_din_be, ui_dout_get, ui_dout); else n_pass++;
        ui_dout_empty = 1'b1;
        ui_din_full = 1'b0;
        mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [15:0] hq_w [$];
        logic [1:0]  hq_be [$];
        logic [15:0] sw [$];
        logic [1:0]  sbe [$];
        bit pop;
        mode = 1'b1;
        ui_dout_empty = 1'b1;
        repeat (3) @(negedge clk);
        cap_clear();
        for (int i = 0; i < 10; i++) begin
            hq_w.push_back(16'($urandom() & 32'hFFFF));
            hq_be.push_back(2'($urandom_range(0, 3)));
        end
        sw = hq_w;
        sbe = hq_be;
        pop = 1'b0;
        for (int c = 0; c < 300 && !(hq_w.size() == 0 && cap_w.size() >= 10); c++) begin
            @(negedge clk);
            if (pop) begin
                void'(hq_w.pop_front());
                void'(hq_be.pop_front());
            end
            ui_dout_empty = (hq_w.size() == 0);
            if (hq_w.size() > 0) begin
                ui_dout    = hq_w[0];
                ui_dout_be = hq_be[0];
            end
            ui_din_full = 1'($urandom_range(0, 1));
            #1;
            pop = ui_dout_get && !ui_dout_empty;
        end
        ui_din_full = 1'b0;
        ui_dout_empty = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (cap_w.size() != 10) $display("FAIL loop_count got %0d want 10", cap_w.size()); else n_pass++;
        for (int i = 0; i < 10 && i < cap_w.size(); i++) begin
            n_checks++; if (cap_w[i] !== sw[i] || cap_be[i] !== sbe[i]) $display("FAIL loop_word%0d got %h/%b want %h/%b", i, cap_w[i], cap_be[i], sw[i], sbe[i]); else n_pass++;
        end
        mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] p;
        bit ok;
        cap_clear();
        @(negedge clk);
        in_data = {rnd_pkt(), rnd_pkt()};
        in_valid = 2'b11;
        @(negedge clk);
        in_valid = '0;
        wait_words(1, 20, ok);
        n_checks++; if (!ok) $display("FAIL rmf_header_timeout got %0d words want 1", cap_w.size()); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (ui_din_valid !== 1'b0) $display("FAIL rmf_during got %b want 0", ui_din_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        n_checks++; if (ui_din_valid !== 1'b0) $display("FAIL rmf_after got %b want 0", ui_din_valid); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (cap_w.size() != 1) $display("FAIL rmf_abandon got %0d words want 1", cap_w.size()); else n_pass++;
        p = rnd_pkt();
        in_data[0 +: DATA_W] = p;
        in_valid = 2'b01;
        m_push(0, p);
        m_emit(m_pick());
        @(negedge clk);
        in_valid = '0;
        wait_words(8, 50, ok);
        n_checks++; if (!ok) $display("FAIL rmf_timeout got %0d words want 8", cap_w.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (cap_w[i+1] !== exp_w[i]) $display("FAIL rmf_word%0d got %h want %h", i, cap_w[i+1], exp_w[i]); else n_pass++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] p;
        logic [1:0]        m;
        bit ok;
        for (int it = 0; it < 3; it++) begin
            cap_clear();
            @(negedge clk);
            ui_din_full = 1'b1;
            m = 2'($urandom_range(1, 3));
            for (int k = 0; k < NUM_CH; k++) begin
                p = rnd_pkt();
                in_data[k*DATA_W +: DATA_W] = p;
                if (m[k]) m_push(k, p);
            end
            in_valid = m;
            m_emit(m_pick());
            @(negedge clk);
            in_valid = '0;
            @(negedge clk);
            for (int c = 0; c < 7; c++) begin
                m = 2'($urandom_range(0, 3));
                for (int k = 0; k < NUM_CH; k++) begin
                    p = rnd_pkt();
                    in_data[k*DATA_W +: DATA_W] = p;
                    if (m[k]) m_push(k, p);
                end
                in_valid = m;
                @(negedge clk);
            end
            in_valid = '0;
            #1;
            for (int k = 0; k < NUM_CH; k++) begin
                n_checks++; if (drop_count[k*16 +: 16] !== 16'(m_drop[k])) $display("FAIL rnd%0d_drop%0d got %0d want %0d", it, k, drop_count[k*16 +: 16], m_drop[k]); else n_pass++;
            end
            m_drain();
            for (int c = 0; c < 400 && cap_w.size() < exp_w.size(); c++) begin
                @(negedge clk);
                ui_din_full = ($urandom_range(0, 3) == 0);
                #3;
            end
            ui_din_full = 1'b0;
            repeat (3) @(negedge clk);
            n_checks++; if (cap_w.size() != exp_w.size()) $display("FAIL rnd%0d_count got %0d want %0d", it, cap_w.size(), exp_w.size()); else n_pass++;
            for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
                n_checks++; if (cap_w[i] !== exp_w[i] || cap_be[i] !== 2'b11) $display("FAIL rnd%0d_word%0d got %h/%b want %h/11", it, i, cap_w[i], cap_be[i], exp_w[i]); else n_pass++;
            end
            n_checks++; if (stab_err != 0) $display("FAIL rnd%0d_stable got %0d want 0", it, stab_err); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_round_robin();
        test_overflow();
        test_backpressure_mode();
        test_loopback();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion (%0d/%0d so far)", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
